// File: rtl/fc_feeder.sv
// fc_feeder: buffers one byte-serial feature frame, streams it to the
// fully connected classifier as LANES-wide beats, waits for the classifier's
// done flag, returns the class over a valid/ready port, and then pulses a
// clear to the classifier before it accepts the next frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_LOAD   | accepting feature bytes into the frame buffer
// S_STREAM | driving one beat per cycle to the classifier, never stalled
// S_WAIT   | all beats sent, waiting for fc_flag_i
// S_RESULT | class latched, res_valid_o high until res_ready_i
// S_CLEAR  | single-cycle fc_clr_o pulse, then back to S_LOAD
module fc_feeder #(
   parameter int N_FEAT = 64,
   parameter int LANES  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid_i,
   input  logic [7:0]         in_data_i,
   output logic               in_ready_o,
   output logic               fc_en_o,
   output logic [LANES*8-1:0] fc_data_o,
   output logic               fc_clr_o,
   input  logic               fc_flag_i,
   input  logic [1:0]         fc_class_i,
   output logic               res_valid_o,
   output logic [1:0]         res_class_o,
   input  logic               res_ready_i,
   output logic               busy_o
);

   localparam int N_BEATS = N_FEAT / LANES;
   localparam int WPW     = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam int BCW     = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
   localparam logic [WPW-1:0] LAST_WP = WPW'(N_FEAT - 1);
   localparam logic [BCW-1:0] LAST_BC = BCW'(N_BEATS - 1);

   typedef enum logic [2:0] {
      S_LOAD,
      S_STREAM,
      S_WAIT,
      S_RESULT,
      S_CLEAR
   } state_t;

   state_t state_q, state_d;

   logic [7:0]         feat_q [N_FEAT];
   logic [WPW-1:0]     wp_q, wp_d;
   logic [BCW-1:0]     bc_q, bc_d;
   logic [LANES*8-1:0] fc_data_q, fc_data_d;
   logic [1:0]         res_class_q, res_class_d;
   logic               fc_en_q, fc_en_d;
   logic               fc_clr_q, fc_clr_d;
   logic               res_valid_q, res_valid_d;

   logic               load_fire;
   logic               frame_done;
   logic [BCW-1:0]     beat_sel;
   logic [WPW-1:0]     idx;
   logic [LANES*8-1:0] beat_d;

   assign load_fire  = (state_q == S_LOAD) && in_valid_i;
   assign frame_done = load_fire && (wp_q == LAST_WP);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_LOAD;
      else     state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:   if (frame_done)          state_d = S_STREAM;
         S_STREAM: if (bc_q == LAST_BC)     state_d = S_WAIT;
         S_WAIT:   if (fc_flag_i)           state_d = S_RESULT;
         S_RESULT: if (res_ready_i)         state_d = S_CLEAR;
         S_CLEAR:                           state_d = S_LOAD;
         default:                           state_d = S_LOAD;
      endcase
   end

   // Output decode: registered outputs follow the state being entered so they
   // line up with it; in_ready/busy decode straight from the current state.
   always_comb begin
      fc_en_d     = (state_d == S_STREAM);
      fc_clr_d    = (state_d == S_CLEAR);
      res_valid_d = (state_d == S_RESULT);
      in_ready_o  = (state_q == S_LOAD);
      busy_o      = (state_q != S_LOAD);
   end

   // Pointer, beat and result datapath. The beat loaded on the completing byte
   // bypasses that byte in case it lands in beat 0 (N_FEAT == LANES).
   always_comb begin
      wp_d        = wp_q;
      bc_d        = bc_q;
      fc_data_d   = fc_data_q;
      res_class_d = res_class_q;
      idx         = '0;
      beat_d      = '0;
      beat_sel    = frame_done ? '0 : bc_q + 1'b1;
      for (int k = 0; k < LANES; k++) begin
         idx = WPW'(beat_sel) * WPW'(LANES) + WPW'(k);
         beat_d[k*8 +: 8] = (load_fire && (idx == wp_q)) ? in_data_i : feat_q[idx];
      end
      if (frame_done) begin
         wp_d      = '0;
         bc_d      = '0;
         fc_data_d = beat_d;
      end else if (load_fire) begin
         wp_d = wp_q + 1'b1;
      end
      if ((state_q == S_STREAM) && (bc_q != LAST_BC)) begin
         bc_d      = bc_q + 1'b1;
         fc_data_d = beat_d;
      end
      if ((state_q == S_WAIT) && fc_flag_i) res_class_d = fc_class_i;
   end

   // Frame buffer; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (load_fire) feat_q[wp_q] <= in_data_i;
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q        <= '0;
         bc_q        <= '0;
         fc_data_q   <= '0;
         res_class_q <= '0;
         fc_en_q     <= 1'b0;
         fc_clr_q    <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         wp_q        <= wp_d;
         bc_q        <= bc_d;
         fc_data_q   <= fc_data_d;
         res_class_q <= res_class_d;
         fc_en_q     <= fc_en_d;
         fc_clr_q    <= fc_clr_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign fc_en_o     = fc_en_q;
   assign fc_data_o   = fc_data_q;
   assign fc_clr_o    = fc_clr_q;
   assign res_valid_o = res_valid_q;
   assign res_class_o = res_class_q;

endmodule

// File: tb/tb_fc_feeder.sv
// Bench for fc_feeder: scoreboard of expected beats and classes, a small
// classifier model that raises fc_flag a programmable delay after beat 15.
module tb_fc_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid, in_ready;
   logic [7:0]  in_data;
   logic        fc_en, fc_clr, fc_flag;
   logic [31:0] fc_data;
   logic [1:0]  fc_class;
   logic        res_valid, res_ready, busy;
   logic [1:0]  res_class;

   fc_feeder #(.N_FEAT(64), .LANES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (in_ready),
      .fc_en_o     (fc_en),
      .fc_data_o   (fc_data),
      .fc_clr_o    (fc_clr),
      .fc_flag_i   (fc_flag),
      .fc_class_i  (fc_class),
      .res_valid_o (res_valid),
      .res_class_o (res_class),
      .res_ready_i (res_ready),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int last_acc = 0;
   logic [31:0] beat_q[$];
   logic [1:0]  cls_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Classifier model: counts beats, raises flag mdl_delay cycles after the
   // edge that ends beat 15 (0 = on that edge), drops it on fc_clr.
   logic       mdl_flag;
   int         mdl_cnt, mdl_beats;
   int         mdl_delay = 0;
   logic [1:0] mdl_class = 2'd0;
   logic       force_flag = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst || fc_clr) begin
         mdl_flag  <= 1'b0;
         mdl_cnt   <= 0;
         mdl_beats <= 0;
      end else if (fc_en) begin
         mdl_beats <= mdl_beats + 1;
         if (mdl_beats == 15) begin
            if (mdl_delay == 0) mdl_flag <= 1'b1;
            else                mdl_cnt  <= mdl_delay;
         end
      end else if (mdl_cnt != 0) begin
         mdl_cnt <= mdl_cnt - 1;
         if (mdl_cnt == 1) mdl_flag <= 1'b1;
      end
   end

   assign fc_flag  = mdl_flag | force_flag;
   assign fc_class = mdl_class;

   // Beat monitor: pops expected beats, checks run length, start latency and
   // that each stream follows a clear (or reset).
   int   run = 0;
   logic clr_ok = 1'b1;
   always @(negedge clk) begin
      if (rst) begin
         run    = 0;
         clr_ok = 1'b1;
      end else begin
         if (fc_clr) clr_ok = 1'b1;
         if (fc_en) begin
            if (run == 0) begin
               check_val("stream_lat", cyc - last_acc, 0);
               check_val("clr_before_stream", clr_ok, 1);
               clr_ok = 1'b0;
            end
            run++;
            check_val("en_excl", {(force_flag ? 1'b0 : fc_flag), fc_clr}, 0);
            if (beat_q.size() == 0) check_val("beat_avail", beat_q.size(), 1);
            else check_val($sformatf("beat%0d", run - 1), fc_data, beat_q.pop_front());
         end else if (run != 0) begin
            check_val("beat_run", run, 16);
            run = 0;
         end
      end
   end

   task automatic send_frame(input logic [7:0] base, input bit toggle, input int n,
                             input logic [1:0] exp_cls);
      int   i   = 0;
      int   tmo = 0;
      logic v   = 1'b0;
      logic [31:0] w;
      if (n == 64) begin
         for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 4; k++) w[k*8 +: 8] = base + 8'(b*4 + k);
            beat_q.push_back(w);
         end
         cls_q.push_back(exp_cls);
      end
      while (i < n && tmo < 1000) begin
         @(negedge clk);
         tmo++;
         v = toggle ? !v : 1'b1;
         in_valid = v;
         in_data  = v ? base + 8'(i) : 8'($urandom);
         if (v && in_ready) begin
            last_acc = cyc + 1;
            i++;
         end
      end
      if (i < n) check_val("load_tmo", i, n);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input int lat, input int hold);
      int n = 0;
      logic [1:0] exp;
      while (!res_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!res_valid) begin
         check_val("res_tmo", res_valid, 1);
         return;
      end
      check_val("res_lat", cyc - last_acc, lat);
      exp = 2'd0;
      if (cls_q.size() == 0) check_val("cls_avail", cls_q.size(), 1);
      else exp = cls_q.pop_front();
      check_val("res_class", res_class, exp);
      mdl_class = mdl_class ^ 2'b11;
      res_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_val("hold_valid", res_valid, 1);
         check_val("hold_class", res_class, exp);
         check_val("hold_no_clr", fc_clr, 0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check_val("clr_pulse", fc_clr, 1);
      check_val("valid_drop", res_valid, 0);
      check_val("clr_in_ready", in_ready, 0);
      check_val("clr_busy", busy, 1);
      @(negedge clk);
      check_val("clr_end", fc_clr, 0);
      check_val("ready_back", in_ready, 1);
      check_val("idle_busy", busy, 0);
   endtask

   task automatic check_reset_vals();
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_fc_en", fc_en, 0);
      check_val("rst_fc_data", fc_data, 0);
      check_val("rst_fc_clr", fc_clr, 0);
      check_val("rst_res_valid", res_valid, 0);
      check_val("rst_res_class", res_class, 0);
      check_val("rst_busy", busy, 0);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1 check_val("rst_en_async", fc_en, 0);
      beat_q.delete();
      cls_q.delete();
      @(negedge clk);
      check_reset_vals();
      #2 rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      in_valid  = 1'b0;
      in_data   = 8'd0;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals();
      #2 rst = 1'b0;

      // Continuous frame 0..63.
      mdl_class = 2'd1;
      mdl_delay = 0;
      send_frame(8'd0, 1'b0, 64, 2'd1);
      check_val("load_done_ready", in_ready, 0);
      check_val("load_done_busy", busy, 1);
      check_val("load_done_en", fc_en, 1);
      wait_result(17, 0);

      // Same bytes with in_valid toggling.
      mdl_class = 2'd0;
      send_frame(8'd0, 1'b1, 64, 2'd0);
      wait_result(17, 0);

      // Flag five cycles late, result held back by res_ready for 10 cycles.
      mdl_class = 2'd2;
      mdl_delay = 5;
      send_frame(8'h40, 1'b0, 64, 2'd2);
      wait_result(22, 10);
      mdl_delay = 0;

      // Back-to-back frames; res_ready held high early must be ignored.
      mdl_class = 2'd3;
      res_ready = 1'b1;
      send_frame(8'd100, 1'b0, 64, 2'd3);
      wait_result(17, 0);
      mdl_class = 2'd0;
      res_ready = 1'b1;
      send_frame(8'd200, 1'b1, 64, 2'd0);
      wait_result(17, 0);

      // Reset after 30 bytes, then a fresh frame.
      send_frame(8'd50, 1'b0, 30, 2'd0);
      do_reset();
      mdl_class = 2'd1;
      send_frame(8'd150, 1'b0, 64, 2'd1);
      wait_result(17, 0);

      // Reset during beat 7, then a fresh frame.
      mdl_class = 2'd3;
      send_frame(8'd70, 1'b0, 64, 2'd3);
      repeat (7) @(negedge clk);
      do_reset();
      mdl_class = 2'd2;
      send_frame(8'd180, 1'b0, 64, 2'd2);
      wait_result(17, 0);

      // Flag stuck high through LOAD and STREAM; class changes on entering WAIT.
      force_flag = 1'b1;
      mdl_class  = 2'd1;
      send_frame(8'd90, 1'b1, 64, 2'd3);
      begin
         int n = 0;
         while (fc_en && n < 40) begin
            @(negedge clk);
            n++;
         end
      end
      check_val("stuck_flag_wait", fc_en, 0);
      check_val("stuck_flag_no_res", res_valid, 0);
      mdl_class = 2'd3;
      wait_result(17, 0);
      force_flag = 1'b0;

      repeat (3) @(negedge clk);
      check_val("beats_drained", beat_q.size(), 0);
      check_val("classes_drained", cls_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
